// File: rtl/forwarding_scoreboard.sv
// Operand-forwarding scoreboard: tracks in-flight writers in a shift register of slots
// and resolves each read port to bypass data, or to a stall while a load is outstanding.
module forwarding_scoreboard #(
   parameter int NREAD   = 2,
   parameter int DEPTH   = 3,
   parameter int LD_SLOT = 1,
   parameter int DW      = 32
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                adv,
   input  logic                flush,
   input  logic                iss_valid,
   input  logic                iss_wen,
   input  logic [4:0]          iss_dst,
   input  logic                iss_rdy,
   input  logic [DW-1:0]       iss_data,
   input  logic                ld_valid,
   input  logic [DW-1:0]       ld_data,
   input  logic [NREAD-1:0]    rd_en,
   input  logic [5*NREAD-1:0]  rd_addr,
   output logic [NREAD-1:0]    fwd_hit,
   output logic [DW*NREAD-1:0] fwd_data,
   output logic                stall,
   output logic [31:0]         stall_cnt
);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] rdy_q, rdy_d;
   logic [4:0]       dst_q  [DEPTH];
   logic [4:0]       dst_d  [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DW-1:0]    data_d [DEPTH];
   logic [31:0]      stall_cnt_q, stall_cnt_d;

   logic             ld_fill;
   logic [NREAD-1:0] pend;
   logic             found;
   logic             sel_rdy;
   logic             sel_ld;
   logic [DW-1:0]    sel_data;

   assign ld_fill = ld_valid & valid_q[LD_SLOT] & ~rdy_q[LD_SLOT];

   // Late data is merged before the shift so it travels with its record
   // (and vanishes with it if that record is the one retiring).
   always_comb begin
      valid_d = valid_q;
      rdy_d   = rdy_q;
      dst_d   = dst_q;
      data_d  = data_q;
      if (ld_fill) begin
         rdy_d[LD_SLOT]  = 1'b1;
         data_d[LD_SLOT] = ld_data;
      end
      if (adv) begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            valid_d[i] = valid_d[i-1];
            rdy_d[i]   = rdy_d[i-1];
            dst_d[i]   = dst_d[i-1];
            data_d[i]  = data_d[i-1];
         end
         valid_d[0] = iss_valid & iss_wen & (iss_dst != 5'd0) & ~flush;
         rdy_d[0]   = iss_rdy;
         dst_d[0]   = iss_dst;
         data_d[0]  = iss_data;
      end else if (flush) begin
         valid_d[0] = 1'b0;
      end
   end

   always_comb begin
      fwd_hit  = '0;
      fwd_data = '0;
      pend     = '0;
      found    = 1'b0;
      sel_rdy  = 1'b0;
      sel_ld   = 1'b0;
      sel_data = '0;
      for (int p = 0; p < NREAD; p++) begin
         found    = 1'b0;
         sel_rdy  = 1'b0;
         sel_ld   = 1'b0;
         sel_data = '0;
         // Scan oldest to youngest so the youngest match is the one left selected.
         for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (dst_q[i] == rd_addr[5*p +: 5])) begin
               found    = 1'b1;
               sel_rdy  = rdy_q[i];
               sel_ld   = (i == LD_SLOT);
               sel_data = data_q[i];
            end
         end
         if (rd_en[p] && (rd_addr[5*p +: 5] != 5'd0) && found) begin
            if (sel_rdy) begin
               fwd_hit[p]          = 1'b1;
               fwd_data[DW*p +: DW] = sel_data;
            end else if (sel_ld && ld_valid) begin
               fwd_hit[p]          = 1'b1;
               fwd_data[DW*p +: DW] = ld_data;
            end else begin
               pend[p] = 1'b1;
            end
         end
      end
   end

   assign stall       = |pend;
   assign stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
   assign stall_cnt   = stall_cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q     <= '0;
         rdy_q       <= '0;
         stall_cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            dst_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         valid_q     <= valid_d;
         rdy_q       <= rdy_d;
         stall_cnt_q <= stall_cnt_d;
         for (int i = 0; i < DEPTH; i++) begin
            dst_q[i]  <= dst_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

endmodule

// File: doc/forwarding_scoreboard.md
FORWARDING_SCOREBOARD -- requirements
Module: forwarding_scoreboard

Interface
REQ-001 SHALL have parameter NREAD, default 2, number of operand read ports.
REQ-002 SHALL have parameter DEPTH, default 3, number of in-flight writer slots (slot 0 youngest, DEPTH-1 oldest); legal 2..8.
REQ-003 SHALL have parameter LD_SLOT, default 1, slot whose pending record is filled by late (load) data; legal 0..DEPTH-1.
REQ-004 SHALL have parameter DW, default 32, data width; register address width fixed at 5.
REQ-005 SHALL have ports: CLK in 1 clock; RST in 1 reset.
REQ-006 SHALL have ports: adv in 1 pipeline advance; flush in 1 kill issuing instruction.
REQ-007 SHALL have ports: iss_valid in 1 issue valid; iss_wen in 1 issue writes a register; iss_dst in 5 destination register.
REQ-008 SHALL have ports: iss_rdy in 1 result available at issue; iss_data in DW issue result.
REQ-009 SHALL have ports: ld_valid in 1 late-data strobe; ld_data in DW late data.
REQ-010 SHALL have ports: rd_en in NREAD port enables; rd_addr in 5*NREAD source registers, port p at bits [5p+4:5p].
REQ-011 SHALL have ports: fwd_hit out NREAD bypass valid; fwd_data out DW*NREAD bypass data; stall out 1 hazard stall.
REQ-012 SHALL have ports: stall_cnt out 32 stall-cycle count.
REQ-013 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-014 SHALL hold per slot: valid, dst[4:0], rdy, data[DW-1:0].
REQ-015 SHALL, on a rising CLK edge with adv=1, shift slot i to slot i+1; the record leaving slot DEPTH-1 retires.
REQ-016 SHALL, on adv=1, load slot 0 with {iss_valid&iss_wen&(iss_dst!=0)&~flush, iss_dst, iss_rdy, iss_data}.
REQ-017 SHALL, on adv=0, hold all slots; flush=1 with adv=0 clears slot 0 valid only.
REQ-018 SHALL, when ld_valid=1 and slot LD_SLOT is valid with rdy=0, set rdy=1 and data=ld_data on that record, landing in slot LD_SLOT+1 if adv=1, in place if adv=0, or dropped if it retires.
REQ-019 SHALL ignore ld_valid when slot LD_SLOT is invalid or already rdy.
REQ-020 SHALL compute lookups combinationally from current slot state: for port p with rd_addr_p=0 or rd_en_p=0, fwd_hit_p=0 and data 0.
REQ-021 SHALL select the youngest (lowest-index) valid slot whose dst equals rd_addr_p; older matches are ignored.
REQ-022 SHALL, if the selected slot is rdy, drive fwd_hit_p=1 and fwd_data_p=slot data.
REQ-023 SHALL, if the selected slot is not rdy but is slot LD_SLOT with ld_valid=1, drive fwd_hit_p=1 and fwd_data_p=ld_data (same-cycle bypass).
REQ-024 SHALL otherwise, for a non-ready match, drive fwd_hit_p=0 and flag port p pending; with no match, fwd_hit_p=0 and data 0.
REQ-025 SHALL drive stall as the OR of the pending flags over enabled ports.
REQ-026 SHALL increment stall_cnt on each edge where stall=1, saturating at 32'hFFFFFFFF.

Reset
REQ-027 SHALL, on a CLK edge with RST=1, clear all slot valid/rdy/dst/data to 0 and stall_cnt to 0, with priority over adv, flush and ld_valid.
REQ-028 SHALL, in the cycle after reset, drive fwd_hit=0, fwd_data=0, stall=0.

Verification
REQ-029 SHALL cover ALU chain: issue dst=3 rdy data=0x11, adv -> rd_addr0=3 gives fwd_hit0=1, data 0x11, stall=0.
REQ-030 SHALL cover load-use: issue dst=5 rdy=0, adv; rd_addr1=5 -> stall=1, stall_cnt increments; adv=0, ld_valid with 0xABCD at LD_SLOT -> fwd_hit1=1, data 0xABCD, stall=0.
REQ-031 SHALL cover priority: dst=7 data 1 in slot 1, dst=7 data 2 in slot 0 -> fwd_data=2; dst=0 issue never hits.
REQ-032 SHALL cover flush: flush=1 with adv=1 on issue dst=4 -> next-cycle lookup of 4 gives fwd_hit=0, stall=0.
REQ-033 SHALL cover retirement: record shifts DEPTH times with adv=1 -> no hit remains; RST mid-pending stall -> stall=0, stall_cnt=0 next cycle.
